// File: rtl/cmp_pkg.sv
// Shared types for the comparator_gt slice cascade: slice width, three-way
// compare result and the MS-first combine rule.
package cmp_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  // The more significant result decides; only a tie defers to the lower slice.
  function automatic cmp_res_t cmp_combine(input cmp_res_t upper, input cmp_res_t lower);
    return (upper == CMP_EQ) ? lower : upper;
  endfunction

endpackage

// File: rtl/comparator_gt_slice.sv
// One 4-bit unsigned compare cell of the comparator_gt cascade.
module comparator_gt_slice
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               gt,
  output logic               eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/comparator_gt.sv
// Registered magnitude comparator built from 4-bit slices, MS slice first.
// Define COMPARATOR_GT_SIGNED_EN for two's-complement operands (default: unsigned).
module comparator_gt
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_valid,
  output logic             o_A_greater_than_B,
  output logic             o_A_equal_B,
  output logic             o_A_less_than_B
);

  localparam int NSLICE = (WIDTH + SLICE_W - 1) / SLICE_W;
  localparam int PAD_W  = NSLICE * SLICE_W;

  logic [WIDTH-1:0]  a_adj;
  logic [WIDTH-1:0]  b_adj;
  logic [PAD_W-1:0]  a_pad;
  logic [PAD_W-1:0]  b_pad;
  logic [NSLICE-1:0] slice_gt;
  logic [NSLICE-1:0] slice_eq;
  cmp_res_t          res;

  always_comb begin
    a_adj = i_A;
    b_adj = i_B;
`ifdef COMPARATOR_GT_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    a_adj[WIDTH-1] = ~i_A[WIDTH-1];
    b_adj[WIDTH-1] = ~i_B[WIDTH-1];
`endif
  end

  // Zero-pad the top slice on the MSB side when WIDTH is not a multiple of 4.
  always_comb begin
    a_pad              = '0;
    b_pad              = '0;
    a_pad[WIDTH-1:0]   = a_adj;
    b_pad[WIDTH-1:0]   = b_adj;
  end

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    comparator_gt_slice u_slice (
      .a  (a_pad[s*SLICE_W +: SLICE_W]),
      .b  (b_pad[s*SLICE_W +: SLICE_W]),
      .gt (slice_gt[s]),
      .eq (slice_eq[s])
    );
  end

  always_comb begin
    res = CMP_EQ;
    for (int s = NSLICE - 1; s >= 0; s--) begin
      res = cmp_combine(res, slice_gt[s] ? CMP_GT : (slice_eq[s] ? CMP_EQ : CMP_LT));
    end
  end

  // i_valid tags the operands for one cycle; o_valid follows one cycle later.
  // Flags load only on a valid cycle and hold otherwise; reset beats i_valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid            <= 1'b0;
      o_A_greater_than_B <= 1'b0;
      o_A_equal_B        <= 1'b0;
      o_A_less_than_B    <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_A_greater_than_B <= (res == CMP_GT);
        o_A_equal_B        <= (res == CMP_EQ);
        o_A_less_than_B    <= (res == CMP_LT);
      end
    end
  end

endmodule

// File: tb/tb_comparator_gt.sv
// Bench for comparator_gt: five widths share one operand bus; directed table,
// hold/reset sequences and a random phase checked against a behavioural model.
module tb_comparator_gt;

`ifdef COMPARATOR_GT_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;
  localparam int         ND = 5;

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic        vld [ND];
  logic        gt  [ND];
  logic        eq  [ND];
  logic        lt  [ND];

  int          n_checks = 0;
  int          n_fail = 0;
  int          widths [ND] = '{1, 4, 7, 12, 16};
  logic [3:0]  exp_q [$];
  logic [2:0]  hold [ND];
  vec_t        vecs [$];

  always #5 clk = ~clk;

  comparator_gt #(.WIDTH(1)) dut_w1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_A(a_bus[0:0]), .i_B(b_bus[0:0]),
    .o_valid(vld[0]), .o_A_greater_than_B(gt[0]), .o_A_equal_B(eq[0]), .o_A_less_than_B(lt[0]));
  comparator_gt #(.WIDTH(4)) dut_w4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_A(a_bus[3:0]), .i_B(b_bus[3:0]),
    .o_valid(vld[1]), .o_A_greater_than_B(gt[1]), .o_A_equal_B(eq[1]), .o_A_less_than_B(lt[1]));
  comparator_gt #(.WIDTH(7)) dut_w7 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_A(a_bus[6:0]), .i_B(b_bus[6:0]),
    .o_valid(vld[2]), .o_A_greater_than_B(gt[2]), .o_A_equal_B(eq[2]), .o_A_less_than_B(lt[2]));
  comparator_gt #(.WIDTH(12)) dut_w12 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_A(a_bus[11:0]), .i_B(b_bus[11:0]),
    .o_valid(vld[3]), .o_A_greater_than_B(gt[3]), .o_A_equal_B(eq[3]), .o_A_less_than_B(lt[3]));
  comparator_gt #(.WIDTH(16)) dut_w16 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_A(a_bus), .i_B(b_bus),
    .o_valid(vld[4]), .o_A_greater_than_B(gt[4]), .o_A_equal_B(eq[4]), .o_A_less_than_B(lt[4]));

  // Behavioural reference: plain integer compare after masking / sign extension.
  function automatic logic [2:0] model(input int w, input logic [15:0] a, input logic [15:0] b);
    longint va;
    longint vb;
    longint mask;
    mask = (longint'(1) << w) - 1;
    va   = longint'(a) & mask;
    vb   = longint'(b) & mask;
    if (SIGNED) begin
      if (va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
      if (vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
    end
    if (va > vb) return GT;
    if (va == vb) return EQ;
    return LT;
  endfunction

  function automatic int idx_of(input int w);
    for (int k = 0; k < ND; k++) if (widths[k] == w) return k;
    return 0;
  endfunction

  function automatic logic [3:0] get_out(input int k);
    return {vld[k], gt[k], eq[k], lt[k]};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,gt,eq,lt}=%b, expected %b", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic v, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    rst   = r;
    valid = v;
    a_bus = a;
    b_bus = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{4,  16'd15,   16'd0,    SIGNED ? LT : GT});
    vecs.push_back('{4,  16'd5,    16'd4,    GT});
    vecs.push_back('{4,  16'd11,   16'd3,    SIGNED ? LT : GT});
    vecs.push_back('{4,  16'd2,    16'd10,   SIGNED ? GT : LT});
    vecs.push_back('{4,  16'd8,    16'd9,    LT});
    vecs.push_back('{4,  16'h7,    16'h8,    SIGNED ? GT : LT});
    vecs.push_back('{4,  16'h8,    16'h8,    EQ});
    vecs.push_back('{12, 16'h100,  16'h0FF,  GT});
    vecs.push_back('{12, 16'h0FF,  16'h100,  LT});
    vecs.push_back('{12, 16'hFFF,  16'hFFF,  EQ});
    vecs.push_back('{12, 16'h800,  16'h7FF,  SIGNED ? LT : GT});
    vecs.push_back('{1,  16'd1,    16'd0,    SIGNED ? LT : GT});
    vecs.push_back('{1,  16'd0,    16'd0,    EQ});
    vecs.push_back('{7,  16'h40,   16'h3F,   SIGNED ? LT : GT});
    vecs.push_back('{7,  16'h12,   16'h13,   LT});
    vecs.push_back('{16, 16'h8000, 16'h7FFF, SIGNED ? LT : GT});
    vecs.push_back('{16, 16'h1234, 16'h1234, EQ});
    vecs.push_back('{16, 16'h0001, 16'h0100, LT});

    // Reset held with a live valid compare: everything stays cleared.
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 16'd15, 16'd0);
      for (int k = 0; k < ND; k++) check($sformatf("reset_hold_w%0d", widths[k]), get_out(k), 4'b0000);
    end
    drive(1'b0, 1'b0, 16'd15, 16'd0);
    for (int k = 0; k < ND; k++) check($sformatf("reset_release_w%0d", widths[k]), get_out(k), 4'b0000);

    // Directed table, back-to-back one compare per cycle.
    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_w%0d", i, vecs[i].w), get_out(idx_of(vecs[i].w)), {1'b1, vecs[i].exp});
      for (int k = 0; k < ND; k++)
        check($sformatf("onehot_vec%0d_w%0d", i, widths[k]), {3'b000, $onehot({gt[k], eq[k], lt[k]})}, 4'b0001);
    end

    // Equality then idle cycles with changing operands: flags must hold.
    drive(1'b0, 1'b1, 16'd7, 16'd7);
    check("eq_7_7_w4", get_out(1), {1'b1, EQ});
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 16'(c), 16'd15);
      check($sformatf("idle_hold%0d_w4", c), get_out(1), {1'b0, EQ});
    end

    // Random phase across all widths with a reset pulse in the middle.
    for (int k = 0; k < ND; k++) hold[k] = EQ;
    for (int i = 0; i < 200; i++) begin
      logic        r;
      logic        v;
      logic [15:0] a;
      logic [15:0] b;
      r = (i == 100);
      v = ($urandom_range(0, 3) != 0);
      a = 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 4) == 0) ? a : 16'($urandom_range(0, 65535));
      for (int k = 0; k < ND; k++) begin
        if (r) hold[k] = 3'b000;
        else if (v) hold[k] = model(widths[k], a, b);
        exp_q.push_back({v & ~r, hold[k]});
      end
      drive(r, v, a, b);
      for (int k = 0; k < ND; k++)
        check($sformatf("rand%0d_w%0d", i, widths[k]), get_out(k), exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
